// File: rtl/fp_pkg.sv
// Purpose: shared constants, stage-1 payload type and rounding helper for the FP add/sub post-add path.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: rounding-mode encodings, fflags bit positions, IEEE single field widths,
// canonical NaN / max-finite patterns, the normalized stage-1 record and the round-up decision.
package fp_pkg;

  localparam int RAW_MANT_W = 28;  // [27] carry, [26] hidden, [25:3] frac, [2] G, [1] R, [0] S
  localparam int INT_EXP_W  = 10;  // biased exponent with headroom for under/overflow
  localparam int NORM_W     = 27;  // normalized significand: hidden..sticky
  localparam int LZC_W      = 5;
  localparam int FP_EXP_W   = 8;
  localparam int FP_FRAC_W  = 23;
  localparam int FP_BIAS    = 127;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

  // Normalized value handed from stage 1 to stage 2.
  typedef struct packed {
    logic                  sign;
    logic [2:0]            rm;
    logic                  eff_sub;
    logic                  is_nan;
    logic                  is_inf;
    logic                  nv;
    logic                  is_zero;
    logic [INT_EXP_W-1:0]  exp;   // two's complement; negative or zero means underflow
    logic [NORM_W-1:0]     mant;  // [26] hidden, [25:3] frac, [2] G, [1] R, [0] S
  } norm_t;

  // Round-up decision. Reserved encodings 101-111 fall back to RNE.
  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic guard, input logic sticky);
    logic inc;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Purpose: 27-bit leading-zero counter used to normalize the raw sum.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: i_vec value to scan (MSB first); o_cnt leading zeros (27 when all zero); o_zero all-zero flag.
module fp_lzc
  import fp_pkg::*;
(
  input  logic [NORM_W-1:0] i_vec,
  output logic [LZC_W-1:0]  o_cnt,
  output logic              o_zero
);

  // Scan from LSB upward so the highest set bit is the last one to assign.
  always_comb begin
    o_cnt = LZC_W'(NORM_W);
    for (int i = 0; i < NORM_W; i++) begin
      if (i_vec[i]) begin
        o_cnt = LZC_W'(NORM_W - 1 - i);
      end
    end
  end

  assign o_zero = ~|i_vec;

endmodule

// File: rtl/fp_norm_round.sv
// Purpose: normalize, round (RNE/RTZ/RDN/RUP/RMM) and pack the FP adder's raw sum into an IEEE single + fflags.
// Latency: 2 cycles from input accept to o_valid; one result per cycle.
// Backpressure: elastic valid/ready; a stalled output holds o_result/o_flags, o_ready drops once both stages are full.
// Ports: i_clk/i_rst (async, active high); i_valid/o_ready upstream handshake carrying i_sign, i_exp,
// i_mant, i_eff_sub, i_rm, i_is_nan, i_is_inf, i_nv; o_valid/i_ready downstream handshake carrying o_result, o_flags.
module fp_norm_round
  import fp_pkg::*;
#(
  parameter int MANT_W = RAW_MANT_W,
  parameter int EXP_W  = INT_EXP_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic                i_sign,
  input  logic [FP_EXP_W-1:0] i_exp,
  input  logic [MANT_W-1:0]   i_mant,
  input  logic                i_eff_sub,
  input  logic [2:0]          i_rm,
  input  logic                i_is_nan,
  input  logic                i_is_inf,
  input  logic                i_nv,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [31:0]         o_result,
  output logic [4:0]          o_flags
);

  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_OVF = EXP_W'(2 * FP_BIAS + 1);

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s1_en, s2_en;

  assign s2_en   = ~s2_valid_q | i_ready;
  assign s1_en   = ~s1_valid_q | s2_en;
  assign o_ready = s1_en;

  // ---------------- stage 1: normalize ----------------
  logic [LZC_W-1:0] lz;
  logic             lz_zero;
  logic [EXP_W-1:0] exp_in;
  logic [EXP_W-1:0] lz_ext;
  norm_t            norm;
  norm_t            s1_q, s1_d;

  fp_lzc u_lzc (
    .i_vec  (i_mant[MANT_W-2:0]),
    .o_cnt  (lz),
    .o_zero (lz_zero)
  );

  assign exp_in = {{(EXP_W-FP_EXP_W){1'b0}}, i_exp};
  assign lz_ext = {{(EXP_W-LZC_W){1'b0}}, lz};

  always_comb begin
    norm         = '0;
    norm.sign    = i_sign;
    norm.rm      = i_rm;
    norm.eff_sub = i_eff_sub;
    norm.is_nan  = i_is_nan;
    norm.is_inf  = i_is_inf;
    norm.nv      = i_nv;
    norm.is_zero = ~i_mant[MANT_W-1] & lz_zero;
    if (i_mant[MANT_W-1]) begin
      // Carry out: shift right one, the dropped bit folds into sticky.
      norm.mant = {i_mant[MANT_W-1:2], i_mant[1] | i_mant[0]};
      norm.exp  = exp_in + EXP_ONE;
    end else begin
      norm.mant = i_mant[MANT_W-2:0] << lz;
      norm.exp  = exp_in - lz_ext;
    end
  end

  // ---------------- stage 2: round and pack ----------------
  logic                 g_bit, s_bit, l_bit, inc;
  logic [NORM_W-3:0]    mant_r;   // [24] carry, [23] hidden, [22:0] fraction
  logic [EXP_W-1:0]     exp_r;
  logic                 uflow, oflow, to_max, zero_sign;
  logic [31:0]          result_c, result_q, result_d;
  logic [4:0]           flags_c, flags_q, flags_d;

  assign g_bit  = s1_q.mant[2];
  assign s_bit  = s1_q.mant[1] | s1_q.mant[0];
  assign l_bit  = s1_q.mant[3];
  assign inc    = round_inc(s1_q.rm, s1_q.sign, l_bit, g_bit, s_bit);
  assign mant_r = {1'b0, s1_q.mant[NORM_W-1:3]} + {{(NORM_W-3){1'b0}}, inc};

  // Top two significand bits read 01 normally and 10 after a round-up carry,
  // so adding them and subtracting one gives the exponent adjustment.
  assign exp_r  = s1_q.exp + {{(EXP_W-2){1'b0}}, mant_r[NORM_W-3:NORM_W-4]} - EXP_ONE;

  // Underflow is judged on the normalized exponent, before rounding.
  assign uflow  = s1_q.exp[EXP_W-1] | (s1_q.exp == '0);
  assign oflow  = ~exp_r[EXP_W-1] & (exp_r >= EXP_OVF);

  // Modes that round toward zero for this sign saturate to max finite instead of inf.
  assign to_max = (s1_q.rm == RM_RTZ) |
                  ((s1_q.rm == RM_RDN) & ~s1_q.sign) |
                  ((s1_q.rm == RM_RUP) &  s1_q.sign);

  // An exact cancellation is +0 except under round-down.
  assign zero_sign = s1_q.eff_sub ? (s1_q.rm == RM_RDN) : s1_q.sign;

  always_comb begin
    result_c          = {s1_q.sign, exp_r[FP_EXP_W-1:0], mant_r[FP_FRAC_W-1:0]};
    flags_c           = '0;
    flags_c[FLAG_DZ]  = 1'b0;
    flags_c[FLAG_NX]  = g_bit | s_bit;
    if (s1_q.is_nan) begin
      result_c         = CANON_NAN;
      flags_c          = '0;
      flags_c[FLAG_NV] = s1_q.nv;
    end else if (s1_q.is_inf) begin
      result_c = {s1_q.sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
      flags_c  = '0;
    end else if (s1_q.is_zero) begin
      result_c = {zero_sign, 31'h0};
      flags_c  = '0;
    end else if (uflow) begin
      result_c         = {s1_q.sign, 31'h0};
      flags_c          = '0;
      flags_c[FLAG_UF] = 1'b1;
      flags_c[FLAG_NX] = 1'b1;
    end else if (oflow) begin
      result_c         = to_max ? {s1_q.sign, MAX_FINITE}
                                : {s1_q.sign, {FP_EXP_W{1'b1}}, {FP_FRAC_W{1'b0}}};
      flags_c          = '0;
      flags_c[FLAG_OF] = 1'b1;
      flags_c[FLAG_NX] = 1'b1;
    end
  end

  // ---------------- pipeline registers ----------------
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    if (s1_en) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_d = norm;
      end
    end
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = result_c;
        flags_d  = flags_c;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign o_valid  = s2_valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

endmodule

// File: tb/tb_fp_norm_round.sv
// Purpose: directed vector bench for fp_norm_round plus backpressure and mid-stream reset sequences.
// Latency: checks the 2-cycle accept-to-valid latency on every vector.
// Backpressure: exercises a full stall (two accepted, third refused) and in-order drain.
module tb_fp_norm_round;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_sign = 1'b0;
  logic [7:0]  i_exp = '0;
  logic [27:0] i_mant = '0;
  logic        i_eff_sub = 1'b0;
  logic [2:0]  i_rm = '0;
  logic        i_is_nan = 1'b0;
  logic        i_is_inf = 1'b0;
  logic        i_nv = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_result;
  logic [4:0]  o_flags;

  fp_norm_round dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_sign    (i_sign),
    .i_exp     (i_exp),
    .i_mant    (i_mant),
    .i_eff_sub (i_eff_sub),
    .i_rm      (i_rm),
    .i_is_nan  (i_is_nan),
    .i_is_inf  (i_is_inf),
    .i_nv      (i_nv),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_result  (o_result),
    .o_flags   (o_flags)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [27:0] mant;
    logic        eff_sub;
    logic [2:0]  rm;
    logic        nan;
    logic        inf;
    logic        nv;
    logic [31:0] res;
    logic [4:0]  flags;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [27:0] m,
                              input logic es, input logic [2:0] rm, input logic nan,
                              input logic inf, input logic nv, input logic [31:0] res,
                              input logic [4:0] fl);
    vec_t v;
    v.sign = s; v.exp = e; v.mant = m; v.eff_sub = es; v.rm = rm;
    v.nan = nan; v.inf = inf; v.nv = nv; v.res = res; v.flags = fl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input vec_t v);
    i_sign = v.sign; i_exp = v.exp; i_mant = v.mant; i_eff_sub = v.eff_sub;
    i_rm = v.rm; i_is_nan = v.nan; i_is_inf = v.inf; i_nv = v.nv;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    bit got;
    @(negedge i_clk);
    drive(v);
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge i_clk);
      if (o_valid) begin
        got = 1;
        lat = c;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'd2);
    chk($sformatf("v%0d_result", idx), o_result, v.res);
    chk($sformatf("v%0d_flags", idx), {27'b0, o_flags}, {27'b0, v.flags});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        bp[3];
    logic [31:0] outs[3];
    int          cyc[3];
    int          idx;
    int          got;
    int          vcnt;
    bit          fire;

    //            s  exp    mant          es rm     nan inf nv  result        flags
    vecs.push_back(mk(0, 8'd127, 28'h8000000, 0, 3'd0, 0, 0, 0, 32'h40000000, 5'b00000));
    vecs.push_back(mk(0, 8'd127, 28'h1000000, 1, 3'd0, 0, 0, 0, 32'h3E800000, 5'b00000));
    vecs.push_back(mk(0, 8'd1,   28'h1000000, 1, 3'd0, 0, 0, 0, 32'h00000000, 5'b00011));
    vecs.push_back(mk(0, 8'd127, 28'h400000C, 0, 3'd0, 0, 0, 0, 32'h3F800002, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h400000C, 0, 3'd1, 0, 0, 0, 32'h3F800001, 5'b00001));
    vecs.push_back(mk(1, 8'd127, 28'h400000C, 0, 3'd3, 0, 0, 0, 32'hBF800001, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h400000C, 0, 3'd3, 0, 0, 0, 32'h3F800002, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h400000C, 0, 3'd7, 0, 0, 0, 32'h3F800002, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h4000004, 0, 3'd0, 0, 0, 0, 32'h3F800000, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h4000004, 0, 3'd4, 0, 0, 0, 32'h3F800001, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h7FFFFFC, 0, 3'd0, 0, 0, 0, 32'h40000000, 5'b00001));
    vecs.push_back(mk(0, 8'd254, 28'h8000000, 0, 3'd0, 0, 0, 0, 32'h7F800000, 5'b00101));
    vecs.push_back(mk(0, 8'd254, 28'h8000000, 0, 3'd1, 0, 0, 0, 32'h7F7FFFFF, 5'b00101));
    vecs.push_back(mk(0, 8'd254, 28'h8000000, 0, 3'd2, 0, 0, 0, 32'h7F7FFFFF, 5'b00101));
    vecs.push_back(mk(1, 8'd254, 28'h8000000, 0, 3'd2, 0, 0, 0, 32'hFF800000, 5'b00101));
    vecs.push_back(mk(1, 8'd254, 28'h8000000, 0, 3'd3, 0, 0, 0, 32'hFF7FFFFF, 5'b00101));
    vecs.push_back(mk(0, 8'd254, 28'h7FFFFFC, 0, 3'd0, 0, 0, 0, 32'h7F800000, 5'b00101));
    vecs.push_back(mk(0, 8'd127, 28'h0000000, 1, 3'd0, 0, 0, 0, 32'h00000000, 5'b00000));
    vecs.push_back(mk(0, 8'd127, 28'h0000000, 1, 3'd2, 0, 0, 0, 32'h80000000, 5'b00000));
    vecs.push_back(mk(1, 8'd127, 28'h0000000, 0, 3'd0, 0, 0, 0, 32'h80000000, 5'b00000));
    vecs.push_back(mk(1, 8'd1,   28'h1000000, 1, 3'd0, 0, 0, 0, 32'h80000000, 5'b00011));
    vecs.push_back(mk(0, 8'd2,   28'h1000000, 1, 3'd0, 0, 0, 0, 32'h00000000, 5'b00011));
    vecs.push_back(mk(0, 8'd3,   28'h1000000, 1, 3'd0, 0, 0, 0, 32'h00800000, 5'b00000));
    vecs.push_back(mk(0, 8'd127, 28'h8000000, 0, 3'd0, 1, 0, 1, 32'h7FC00000, 5'b10000));
    vecs.push_back(mk(1, 8'd127, 28'h8000000, 0, 3'd0, 1, 1, 0, 32'h7FC00000, 5'b00000));
    vecs.push_back(mk(1, 8'd127, 28'h8000000, 0, 3'd0, 0, 1, 0, 32'hFF800000, 5'b00000));
    vecs.push_back(mk(0, 8'd127, 28'h4000000, 0, 3'd0, 0, 0, 0, 32'h3F800000, 5'b00000));
    vecs.push_back(mk(0, 8'd127, 28'h8000001, 0, 3'd0, 0, 0, 0, 32'h40000000, 5'b00001));
    vecs.push_back(mk(0, 8'd127, 28'h8000001, 0, 3'd3, 0, 0, 0, 32'h40000001, 5'b00001));

    // Reset state
    repeat (3) @(negedge i_clk);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'h0);
    chk("rst_flags", {27'b0, o_flags}, 32'd0);
    i_rst = 1'b0;
    #1 chk("rst_ready", {31'b0, o_ready}, 32'd1);

    // Directed vectors
    for (int k = 0; k < vecs.size(); k++) begin
      run_vec(vecs[k], k);
    end

    // Backpressure: downstream stalled, three inputs offered back to back
    bp[0] = vecs[0];
    bp[1] = vecs[3];
    bp[2] = vecs[1];
    @(negedge i_clk);
    i_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      drive(bp[(idx > 2) ? 2 : idx]);
      i_valid = 1'b1;
      #1 fire = o_ready;
      @(posedge i_clk);
      if (fire) idx++;
      @(negedge i_clk);
    end
    chk("bp_accepted", 32'(idx), 32'd2);
    chk("bp_ready_low", {31'b0, o_ready}, 32'd0);
    chk("bp_valid", {31'b0, o_valid}, 32'd1);
    chk("bp_result", o_result, bp[0].res);
    repeat (2) @(negedge i_clk);
    chk("bp_hold_result", o_result, bp[0].res);
    chk("bp_hold_flags", {27'b0, o_flags}, {27'b0, bp[0].flags});

    // Release and drain
    if (idx >= 3) i_valid = 1'b0;
    i_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 3; k++) begin
      outs[k] = '0;
      cyc[k]  = 0;
    end
    for (int c = 0; c < 12 && got < 3; c++) begin
      #1;
      if (o_valid) begin
        outs[got] = o_result;
        cyc[got]  = c;
        got++;
      end
      fire = o_ready & i_valid;
      @(posedge i_clk);
      if (fire) idx++;
      #1 if (idx >= 3) i_valid = 1'b0;
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("drain_count", 32'(got), 32'd3);
    chk("drain_res0", outs[0], bp[0].res);
    chk("drain_res1", outs[1], bp[1].res);
    chk("drain_res2", outs[2], bp[2].res);
    chk("drain_gap01", 32'(cyc[1] - cyc[0]), 32'd1);
    chk("drain_gap12", 32'(cyc[2] - cyc[1]), 32'd1);
    repeat (2) @(negedge i_clk);
    chk("drain_empty", {31'b0, o_valid}, 32'd0);

    // Reset with one result at the output and another in stage 1
    @(negedge i_clk);
    drive(vecs[0]);
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    drive(vecs[3]);
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    chk("rst_mid_pre_valid", {31'b0, o_valid}, 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_mid_result", o_result, 32'h0);
    chk("rst_mid_flags", {27'b0, o_flags}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    vcnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (o_valid) vcnt++;
    end
    chk("rst_mid_no_emit", 32'(vcnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
